// File: rtl/if_id_latch_if.sv
// IF/ID pipeline-register bus: fetch-side inputs and hazard controls in,
// registered decode-side outputs out.
interface if_id_latch_if #(
    parameter int WIDTH = 32
);
    // Handshake: there is no valid/ready pair. When en=1 the latch accepts
    // npc/instr on every rising edge. en=0 stalls (holds) and flush=1 squashes,
    // with flush taking priority. valid_out marks a real instruction in instrout.
    logic             en;
    logic             flush;
    logic [WIDTH-1:0] npc;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] npcout;
    logic [WIDTH-1:0] instrout;
    logic             valid_out;

    modport master (
        output en, flush, npc, instr,
        input  npcout, instrout, valid_out
    );

    modport slave (
        input  en, flush, npc, instr,
        output npcout, instrout, valid_out
    );
endinterface

// File: rtl/if_id_latch.sv
// IF/ID pipeline register. It captures npc/instr on each edge, supports
// stall (hold) and flush (bubble), and tracks whether the slot is valid.
module if_id_latch #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_INSTR = '0
) (
    input  logic         clk,
    input  logic         rst,
    if_id_latch_if.slave bus
);

    logic [WIDTH-1:0] npc_q,   npc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             valid_q, valid_d;

    // Flush is tested before en. A squashed slot never samples the data
    // inputs, so X on npc/instr during a flush or stall cannot reach the flops.
    always_comb begin
        npc_d   = npc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (bus.flush) begin
            npc_d   = '0;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (bus.en) begin
            npc_d   = bus.npc;
            instr_d = bus.instr;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            npc_q   <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            npc_q   <= npc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign bus.npcout    = npc_q;
    assign bus.instrout  = instr_q;
    assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_if_id_latch.sv
// Directed bench for if_id_latch: reset, load, stall, flush, async reset, streaming.
module tb_if_id_latch;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    if_id_latch_if #(.WIDTH(W)) bus ();

    if_id_latch #(.WIDTH(W), .NOP_INSTR(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and return on the following falling edge,
    // where outputs are sampled and new inputs are driven.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [2*W:0] got;
        rst       = 1'b1;
        bus.en    = 1'b1;
        bus.flush = 1'b0;
        bus.npc   = 32'd10;
        bus.instr = 32'd12;
        #1;
        got = {bus.npcout, bus.instrout, bus.valid_out};
        checks++;
        if (got !== {32'd0, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_before_edge: got npc=%h instr=%h v=%b, want 0/0/0",
                     got[2*W:W+1], got[W:1], got[0]);
        end
        step();
        step();
        got = {bus.npcout, bus.instrout, bus.valid_out};
        checks++;
        if (got !== {32'd0, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_with_clock: got npc=%h instr=%h v=%b, want 0/0/0",
                     got[2*W:W+1], got[W:1], got[0]);
        end
    endtask

    task automatic test_load();
        logic [2*W:0] got;
        rst       = 1'b0;
        bus.en    = 1'b1;
        bus.npc   = 32'd0;
        bus.instr = 32'd0;
        step();
        got = {bus.npcout, bus.instrout, bus.valid_out};
        checks++;
        if (got !== {32'd0, 32'd0, 1'b1}) begin
            failures++;
            $display("FAIL load_zero: got npc=%h instr=%h v=%b, want 0/0/1",
                     got[2*W:W+1], got[W:1], got[0]);
        end
        bus.npc   = 32'd10;
        bus.instr = 32'd12;
        step();
        got = {bus.npcout, bus.instrout, bus.valid_out};
        checks++;
        if (got !== {32'd10, 32'd12, 1'b1}) begin
            failures++;
            $display("FAIL load_10_12: got npc=%h instr=%h v=%b, want a/c/1",
                     got[2*W:W+1], got[W:1], got[0]);
        end
        #1;
        bus.npc   = 32'd99;
        bus.instr = 32'd77;
        #1;
        got = {bus.npcout, bus.instrout, bus.valid_out};
        checks++;
        if (got !== {32'd10, 32'd12, 1'b1}) begin
            failures++;
            $display("FAIL load_mid_cycle: got npc=%h instr=%h v=%b, want a/c/1",
                     got[2*W:W+1], got[W:1], got[0]);
        end
    endtask

    task automatic test_stall();
        logic [2*W:0] got;
        bus.en    = 1'b0;
        bus.npc   = 32'd20;
        bus.instr = 32'h8C01_0004;
        for (int i = 0; i < 3; i++) begin
            step();
            got = {bus.npcout, bus.instrout, bus.valid_out};
            checks++;
            if (got !== {32'd10, 32'd12, 1'b1}) begin
                failures++;
                $display("FAIL stall_hold_%0d: got npc=%h instr=%h v=%b, want a/c/1",
                         i, got[2*W:W+1], got[W:1], got[0]);
            end
        end
        bus.en = 1'b1;
        step();
        got = {bus.npcout, bus.instrout, bus.valid_out};
        checks++;
        if (got !== {32'd20, 32'h8C01_0004, 1'b1}) begin
            failures++;
            $display("FAIL stall_release: got npc=%h instr=%h v=%b, want 14/8c010004/1",
                     got[2*W:W+1], got[W:1], got[0]);
        end
    endtask

    task automatic test_flush();
        logic [2*W:0] got;
        bus.flush = 1'b1;
        bus.en    = 1'b0;
        bus.npc   = 'x;
        bus.instr = 'x;
        step();
        got = {bus.npcout, bus.instrout, bus.valid_out};
        checks++;
        if (got !== {32'd0, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL flush_over_stall: got npc=%h instr=%h v=%b, want 0/0/0",
                     got[2*W:W+1], got[W:1], got[0]);
        end
        bus.flush = 1'b1;
        bus.en    = 1'b1;
        bus.npc   = 32'd44;
        bus.instr = 32'h1111_2222;
        step();
        got = {bus.npcout, bus.instrout, bus.valid_out};
        checks++;
        if (got !== {32'd0, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL flush_over_load: got npc=%h instr=%h v=%b, want 0/0/0",
                     got[2*W:W+1], got[W:1], got[0]);
        end
        bus.flush = 1'b0;
        bus.en    = 1'b1;
        bus.npc   = 32'd24;
        bus.instr = 32'h2002_0005;
        step();
        got = {bus.npcout, bus.instrout, bus.valid_out};
        checks++;
        if (got !== {32'd24, 32'h2002_0005, 1'b1}) begin
            failures++;
            $display("FAIL flush_release: got npc=%h instr=%h v=%b, want 18/20020005/1",
                     got[2*W:W+1], got[W:1], got[0]);
        end
    endtask

    task automatic test_async_reset();
        logic [2*W:0] got;
        bus.en    = 1'b0;
        bus.npc   = 'x;
        bus.instr = 'x;
        step();
        got = {bus.npcout, bus.instrout, bus.valid_out};
        checks++;
        if (got !== {32'd24, 32'h2002_0005, 1'b1}) begin
            failures++;
            $display("FAIL stall_x_inputs: got npc=%h instr=%h v=%b, want 18/20020005/1",
                     got[2*W:W+1], got[W:1], got[0]);
        end
        #1;
        rst = 1'b1;
        #1;
        got = {bus.npcout, bus.instrout, bus.valid_out};
        checks++;
        if (got !== {32'd0, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset_mid: got npc=%h instr=%h v=%b, want 0/0/0",
                     got[2*W:W+1], got[W:1], got[0]);
        end
        #1;
        rst       = 1'b0;
        bus.en    = 1'b1;
        bus.npc   = 32'd28;
        bus.instr = 32'h0000_0ABC;
        step();
        got = {bus.npcout, bus.instrout, bus.valid_out};
        checks++;
        if (got !== {32'd28, 32'h0000_0ABC, 1'b1}) begin
            failures++;
            $display("FAIL after_async_reset: got npc=%h instr=%h v=%b, want 1c/abc/1",
                     got[2*W:W+1], got[W:1], got[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W:0] got;
        logic [W-1:0] npc_v   [4];
        logic [W-1:0] instr_v [4];
        npc_v   = '{32'd4, 32'd8, 32'd12, 32'd16};
        instr_v = '{32'h2408_0001, 32'hAC09_0008, 32'hFFFF_FFFF, 32'h8000_0001};
        bus.en    = 1'b1;
        bus.flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.npc   = npc_v[i];
            bus.instr = instr_v[i];
            step();
            got = {bus.npcout, bus.instrout, bus.valid_out};
            checks++;
            if (got !== {npc_v[i], instr_v[i], 1'b1}) begin
                failures++;
                $display("FAIL stream_%0d: got npc=%h instr=%h v=%b, want %h/%h/1",
                         i, got[2*W:W+1], got[W:1], got[0], npc_v[i], instr_v[i]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_load();
        test_stall();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
